// File: rtl/i2s_fifo_tx_if.sv
// Read-side bundle of the left/right gain-stage output FIFOs (first-word fall-through).
// The FIFO pair is the master; the I2S transmitter consumes through the slave modport.
interface i2s_fifo_tx_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  left_empty;
    logic [DATA_WIDTH-1:0] left_dout;
    logic                  left_rd_en;
    logic                  right_empty;
    logic [DATA_WIDTH-1:0] right_dout;
    logic                  right_rd_en;

    modport master (
        output left_empty, left_dout, right_empty, right_dout,
        input  left_rd_en, right_rd_en
    );

    modport slave (
        input  left_empty, left_dout, right_empty, right_dout,
        output left_rd_en, right_rd_en
    );
endinterface

// File: rtl/i2s_fifo_tx.sv
// I2S transmitter: pops L/R sample pairs from two FIFOs, saturates them to SAMPLE_BITS,
// and serializes standard I2S frames with a one-pair prefetch and underflow counting.
module i2s_fifo_tx #(
    parameter int DATA_WIDTH  = 32,
    parameter int SAMPLE_BITS = 16,
    parameter int CLK_DIV     = 8,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    i2s_fifo_tx_if.slave         fifo,
    output logic                 i2s_bclk,
    output logic                 i2s_lrclk,
    output logic                 i2s_sdata,
    output logic [CNT_WIDTH-1:0] underflow_count
);
    localparam int FRAME_BITS = 2 * SAMPLE_BITS;
    localparam int DIV_W      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int K_W        = $clog2(FRAME_BITS);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [K_W-1:0]   K_LAST   = K_W'(FRAME_BITS - 1);
    localparam logic [K_W-1:0]   LR_FIRST = K_W'(SAMPLE_BITS - 1);
    localparam logic [K_W-1:0]   LR_LAST  = K_W'(FRAME_BITS - 2);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // In range exactly when every bit from the sample sign bit upward agrees.
    function automatic logic [SAMPLE_BITS-1:0] saturate(input logic [DATA_WIDTH-1:0] w);
        logic [DATA_WIDTH-SAMPLE_BITS:0] head;
        head = w[DATA_WIDTH-1:SAMPLE_BITS-1];
        if ((&head) || !(|head)) begin
            saturate = w[SAMPLE_BITS-1:0];
        end else if (w[DATA_WIDTH-1]) begin
            saturate = {1'b1, {(SAMPLE_BITS-1){1'b0}}};
        end else begin
            saturate = {1'b0, {(SAMPLE_BITS-1){1'b1}}};
        end
    endfunction

    state_t                 state_q;
    logic                   hold_valid_q;
    logic [SAMPLE_BITS-1:0] hold_l_q;
    logic [SAMPLE_BITS-1:0] hold_r_q;
    logic [FRAME_BITS-1:0]  shift_q;
    logic [DIV_W-1:0]       div_q;
    logic [K_W-1:0]         k_q;
    logic                   bclk_q;
    logic                   lrclk_q;
    logic                   rd_en_q;
    logic [CNT_WIDTH-1:0]   uf_cnt_q;

    logic                   pop_d;
    logic [K_W-1:0]         k_next_s;
    logic                   lr_next_s;

    // Pop decision: one pair at a time, only into an empty holding register, never while a pop is in flight.
    always_comb begin
        pop_d     = 1'b0;
        k_next_s  = k_q + K_W'(1);
        lr_next_s = 1'b0;
        if (!hold_valid_q && !rd_en_q && !fifo.left_empty && !fifo.right_empty) begin
            pop_d = 1'b1;
        end else begin
            pop_d = 1'b0;
        end
        if ((k_next_s >= LR_FIRST) && (k_next_s <= LR_LAST)) begin
            lr_next_s = 1'b1;
        end else begin
            lr_next_s = 1'b0;
        end
    end

    // Transmitter FSM, bit-clock divider, frame shifter, holding register and underflow counter.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            hold_valid_q <= 1'b0;
            hold_l_q     <= '0;
            hold_r_q     <= '0;
            shift_q      <= '0;
            div_q        <= '0;
            k_q          <= '0;
            bclk_q       <= 1'b0;
            lrclk_q      <= 1'b0;
            rd_en_q      <= 1'b0;
            uf_cnt_q     <= '0;
        end else begin
            rd_en_q <= pop_d;
            case (state_q)
                ST_IDLE: begin
                    if (hold_valid_q) begin
                        state_q      <= ST_RUN;
                        shift_q      <= {hold_l_q, hold_r_q};
                        hold_valid_q <= 1'b0;
                        div_q        <= '0;
                        k_q          <= '0;
                        bclk_q       <= 1'b0;
                        lrclk_q      <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (div_q == DIV_LAST) begin
                        div_q  <= '0;
                        bclk_q <= ~bclk_q;
                        // Data and word select only move on the falling toggle.
                        if (bclk_q) begin
                            if (k_q == K_LAST) begin
                                k_q     <= '0;
                                lrclk_q <= 1'b0;
                                if (hold_valid_q) begin
                                    shift_q      <= {hold_l_q, hold_r_q};
                                    hold_valid_q <= 1'b0;
                                end else begin
                                    shift_q <= '0;
                                    if (uf_cnt_q != {CNT_WIDTH{1'b1}}) begin
                                        uf_cnt_q <= uf_cnt_q + CNT_WIDTH'(1);
                                    end
                                end
                            end else begin
                                k_q     <= k_next_s;
                                shift_q <= {shift_q[FRAME_BITS-2:0], 1'b0};
                                lrclk_q <= lr_next_s;
                            end
                        end
                    end else begin
                        div_q <= div_q + DIV_W'(1);
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
            // A pop only happens while the holding register is empty, so this never collides with a load above.
            if (rd_en_q) begin
                hold_l_q     <= saturate(fifo.left_dout);
                hold_r_q     <= saturate(fifo.right_dout);
                hold_valid_q <= 1'b1;
            end
        end
    end

    assign fifo.left_rd_en  = rd_en_q;
    assign fifo.right_rd_en = rd_en_q;
    assign i2s_bclk         = bclk_q;
    assign i2s_lrclk        = lrclk_q;
    assign i2s_sdata        = shift_q[FRAME_BITS-1];
    assign underflow_count  = uf_cnt_q;
endmodule

// File: tb/tb_i2s_fifo_tx.sv
// Bench for i2s_fifo_tx: queue-based FIFO model, serial-frame decoder and a pair-level
// reference model (saturated pairs in pop order, silent frames counted as underflow).
`timescale 1ns/1ps
module tb_i2s_fifo_tx;
    localparam int DW       = 32;
    localparam int SB       = 16;
    localparam int CD       = 2;
    localparam int CW       = 16;
    localparam int STREAM_N = 160;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          i2s_bclk, i2s_lrclk, i2s_sdata;
    logic [CW-1:0] underflow_count;

    i2s_fifo_tx_if #(.DATA_WIDTH(DW)) fifo_if ();

    i2s_fifo_tx #(
        .DATA_WIDTH(DW), .SAMPLE_BITS(SB), .CLK_DIV(CD), .CNT_WIDTH(CW)
    ) dut (
        .clock(clock), .reset(reset), .fifo(fifo_if),
        .i2s_bclk(i2s_bclk), .i2s_lrclk(i2s_lrclk), .i2s_sdata(i2s_sdata),
        .underflow_count(underflow_count)
    );

    always #5 clock = ~clock;

    int          total = 0, bad = 0;
    logic [31:0] lq[$], rq[$], exp_q[$];
    int          model_uf = 0, pops = 0, frames_rx = 0, frames_since_rst = 0;
    int          bitpos = 0, clk_since_rise = 0;
    bit          have_rise = 1'b0, prev_bclk = 1'b0, pend = 1'b0, prev_pend = 1'b0;
    logic [31:0] fr_data = 32'h0, fr_lr = 32'h0, last_frame = 32'h0, lr_exp = 32'h0;
    logic [20:0] outs;

    assign outs = {i2s_bclk, i2s_lrclk, i2s_sdata, fifo_if.left_rd_en, fifo_if.right_rd_en, underflow_count};

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] sat16(input logic [31:0] w);
        int v;
        v = $signed(w);
        if (v > 32767) return 16'h7FFF;
        else if (v < -32768) return 16'h8000;
        else return w[15:0];
    endfunction

    function automatic logic [31:0] rand_word();
        logic [31:0] w;
        logic [15:0] t;
        t = 16'($urandom);
        case ($urandom_range(0, 3))
            0:       w = {{16{t[15]}}, t};
            1:       w = $urandom_range(32'h0000_8000, 32'h7FFF_FFFF);
            2:       w = $urandom_range(32'h8000_0000, 32'hFFFF_7FFF);
            default: w = $urandom;
        endcase
        return w;
    endfunction

    task automatic push_pair(input logic [31:0] l, input logic [31:0] r);
        lq.push_back(l);
        rq.push_back(r);
    endtask

    // FIFO model: a rd_en seen during a cycle pops both queues at the closing edge.
    initial begin
        fifo_if.left_empty  = 1'b1;
        fifo_if.right_empty = 1'b1;
        fifo_if.left_dout   = 32'h0;
        fifo_if.right_dout  = 32'h0;
    end

    always begin
        @(negedge clock);
        pend = fifo_if.left_rd_en | fifo_if.right_rd_en;
        if (pend) begin
            chk("rd_en_pair", {fifo_if.left_rd_en, fifo_if.right_rd_en}, 2'b11);
            chk("rd_en_nonempty", (lq.size() > 0 && rq.size() > 0), 1'b1);
            chk("rd_en_single", prev_pend, 1'b0);
        end
        prev_pend = pend;
        @(posedge clock);
        #1;
        if (pend && lq.size() > 0 && rq.size() > 0) begin
            exp_q.push_back({sat16(lq[0]), sat16(rq[0])});
            void'(lq.pop_front());
            void'(rq.pop_front());
            pops++;
        end
        fifo_if.left_empty  = (lq.size() == 0);
        fifo_if.right_empty = (rq.size() == 0);
        fifo_if.left_dout   = (lq.size() > 0) ? lq[0] : 32'h0;
        fifo_if.right_dout  = (rq.size() > 0) ? rq[0] : 32'h0;
    end

    // Serial decoder: collects bits on bclk rising edges and scores each 2*SB-bit frame.
    always begin
        @(negedge clock);
        if (!reset) begin
            bitpos = 0; have_rise = 1'b0; prev_bclk = 1'b0; clk_since_rise = 0;
            frames_since_rst = 0; fr_data = 32'h0; fr_lr = 32'h0;
        end else begin
            clk_since_rise++;
            if (i2s_bclk && !prev_bclk) begin
                if (have_rise) chk("bclk_period", clk_since_rise, 2 * CD);
                have_rise = 1'b1;
                clk_since_rise = 0;
                fr_data = {fr_data[30:0], i2s_sdata};
                fr_lr   = {fr_lr[30:0], i2s_lrclk};
                bitpos++;
                if (bitpos == 2 * SB) begin
                    frames_rx++;
                    frames_since_rst++;
                    last_frame = fr_data;
                    chk("lrclk_frame", fr_lr, lr_exp);
                    if (fr_data == 32'h0) begin
                        model_uf++;
                    end else if (exp_q.size() > 0) begin
                        chk("frame_data", fr_data, exp_q[0]);
                        void'(exp_q.pop_front());
                    end else begin
                        chk("frame_unexpected", fr_data, 32'h0);
                    end
                    chk("uf_count", underflow_count, model_uf);
                    bitpos = 0;
                end
            end
            prev_bclk = i2s_bclk;
        end
    end

    task automatic wait_frames(input int n, input int budget, input string tag);
        int c = 0;
        while (frames_rx < n && c < budget) begin @(negedge clock); #1; c++; end
        if (frames_rx < n) chk(tag, frames_rx, n);
    endtask

    task automatic wait_fsr(input int n, input int budget, input string tag);
        int c = 0;
        while (frames_since_rst < n && c < budget) begin @(negedge clock); #1; c++; end
        if (frames_since_rst < n) chk(tag, frames_since_rst, n);
    endtask

    task automatic wait_pops(input int n, input int budget, input string tag);
        int c = 0;
        while (pops < n && c < budget) begin @(negedge clock); #1; c++; end
        if (pops < n) chk(tag, pops, n);
    endtask

    task automatic wait_bitpos(input int uf_min, input int bp, input int budget, input string tag);
        int c = 0;
        while (!(model_uf >= uf_min && bitpos == bp) && c < budget) begin @(negedge clock); #1; c++; end
        if (c >= budget) chk(tag, bitpos, bp);
    endtask

    task automatic wait_expq_empty(input int budget, input string tag);
        int c = 0;
        while (exp_q.size() > 0 && c < budget) begin @(negedge clock); #1; c++; end
        if (exp_q.size() > 0) chk(tag, exp_q.size(), 0);
    endtask

    task automatic hard_reset();
        @(posedge clock);
        #3;
        reset = 1'b0;
        #1;
        chk("rst_async_outputs", outs, 21'h0);
        lq.delete(); rq.delete(); exp_q.delete();
        model_uf = 0;
        repeat (5) @(negedge clock);
        reset = 1'b1;
    endtask

    initial begin
        logic [20:0] quiet;
        int          f0, p0;
        logic [31:0] edge_l[5];
        logic [31:0] edge_r[5];

        for (int i = 0; i < 2 * SB; i++)
            lr_exp[2*SB-1-i] = (i >= SB - 1 && i <= 2 * SB - 2);

        #2 reset = 1'b0;
        repeat (3) @(posedge clock);
        #1 chk("rst_outputs", outs, 21'h0);
        @(negedge clock) reset = 1'b1;

        quiet = 21'h0;
        repeat (200) begin @(negedge clock); #1; quiet = quiet | outs; end
        chk("idle_quiet", quiet, 21'h0);

        push_pair(32'h0000_1234, 32'hFFFF_ABCD);
        wait_pops(1, 50, "pop1_timeout");
        repeat (20) @(negedge clock);
        chk("pop1_single", pops, 1);
        f0 = frames_rx;
        push_pair(32'h0001_2345, 32'hFFFE_0000);
        push_pair(32'hFFFF_8000, 32'h0000_7FFF);
        wait_frames(f0 + 1, 400, "frame1_timeout");
        chk("frame_1234_abcd", last_frame, 32'h1234_ABCD);
        wait_frames(f0 + 2, 400, "frame2_timeout");
        chk("frame_sat_pos_neg", last_frame, 32'h7FFF_8000);
        wait_frames(f0 + 3, 400, "frame3_timeout");
        chk("frame_min_max_kept", last_frame, 32'h8000_7FFF);

        // Third silent frame is under way once two are complete and a few bits are in.
        wait_bitpos(2, 4, 800, "uf_window_timeout");
        f0 = frames_rx;
        push_pair(32'h0000_0001, 32'h0000_0002);
        wait_frames(f0 + 2, 400, "uf_recover_timeout");
        chk("frame_after_uf", last_frame, 32'h0001_0002);
        chk("uf_count_3", underflow_count, 16'd3);

        p0 = pops;
        lq.push_back(32'h0000_0777);
        repeat (100) @(negedge clock);
        chk("left_only_no_pop", pops, p0);
        rq.push_back(32'hFFFF_F000);
        wait_pops(p0 + 1, 20, "pair_pop_timeout");
        chk("pair_both_popped", {lq.size() == 0, rq.size() == 0}, 2'b11);
        wait_expq_empty(400, "pair_frame_timeout");

        hard_reset();
        edge_l = '{32'h0000_7FFF, 32'h0000_8000, 32'hFFFF_8000, 32'hFFFF_7FFF, 32'h7FFF_FFFF};
        edge_r = '{32'hFFFF_8000, 32'h8000_0000, 32'h0000_7FFF, 32'h0000_0000, 32'hFFFF_FFFF};
        for (int i = 0; i < 5; i++) push_pair(edge_l[i], edge_r[i]);
        for (int i = 5; i < STREAM_N; i++) push_pair(rand_word() | 32'h1, rand_word());
        wait_fsr(STREAM_N - 3, STREAM_N * 140, "stream_timeout");
        chk("stream_uf_zero", underflow_count, 16'd0);
        chk("stream_model_uf", model_uf, 0);
        wait_bitpos(0, 8, 200, "midframe_timeout");

        hard_reset();
        push_pair(32'h0000_0055, 32'hFFFF_FF00);
        wait_fsr(1, 400, "post_rst_timeout");
        chk("post_rst_frame", last_frame, 32'h0055_FF00);
        chk("post_rst_first", frames_since_rst, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
